// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 ABCD vectors into a 4-input function unit and records its g/h outputs.
// Optional macro SWEEP_COMPARE_EN adds comparison against expected tables (mismatch_cnt, pass).
module truth_table_sweeper #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_g,
    input  logic [15:0] exp_h,
    output logic [3:0]  abcd,
    input  logic        g_in,
    input  logic        h_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] g_table,
    output logic [15:0] h_table,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d, cnt_q, cnt_d;
    logic [15:0] g_q, g_d, h_q, h_d, eg_q, eg_d, eh_q, eh_d;
    logic [4:0]  mm_q, mm_d;
    logic        pass_q, pass_d, done_q, done_d;
    logic        miss;
    logic        cmp_en;

`ifdef SWEEP_COMPARE_EN
    assign cmp_en = 1'b1;
    assign miss   = (g_in != eg_q[idx_q]) || (h_in != eh_q[idx_q]);
`else
    logic unused_cmp;
    assign cmp_en     = 1'b0;
    assign miss       = 1'b0;
    assign unused_cmp = ^{eg_q, eh_q};
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        h_d     = h_q;
        eg_d    = eg_q;
        eh_d    = eh_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    g_d     = 16'd0;
                    h_d     = 16'd0;
                    mm_d    = 5'd0;
                    pass_d  = 1'b0;
                    eg_d    = exp_g;
                    eh_d    = exp_h;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPTURE: begin
                // abort wins over the capture in the same cycle
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    g_d[idx_q] = g_in;
                    h_d[idx_q] = h_in;
                    mm_d       = mm_q + 5'(miss);
                    state_d    = (idx_q == 4'd15) ? DONE : SETTLE;
                    idx_d      = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = cmp_en && (mm_q == 5'd0);
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            g_q     <= 16'd0;
            h_q     <= 16'd0;
            eg_q    <= 16'd0;
            eh_q    <= 16'd0;
            mm_q    <= 5'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            h_q     <= h_d;
            eg_q    <= eg_d;
            eh_q    <= eh_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign abcd         = idx_q;
    assign busy         = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done         = done_q;
    assign g_table      = g_q;
    assign h_table      = h_q;
    assign mismatch_cnt = mm_q;
    assign pass         = pass_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps against a modelled function unit, scoreboarded results.
module tb_truth_table_sweeper;
    localparam int S   = 2;
    localparam int LAT = 16 * (S + 1) + 1;

    typedef struct {
        logic [15:0] g;
        logic [15:0] h;
        logic [4:0]  mm;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, g_in, h_in, busy, done, pass;
    logic [15:0] exp_g, exp_h, g_table, h_table;
    logic [15:0] fu_g = 16'hF37A;
    logic [15:0] fu_h = 16'h5E0B;
    logic [3:0]  abcd;
    logic [4:0]  mismatch_cnt;
    exp_t        sb[$];
    exp_t        e;
    int          n = 0;
    int          fails = 0;
    int          cyc;
    int          dones;

    truth_table_sweeper #(.SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .exp_g(exp_g), .exp_h(exp_h), .abcd(abcd),
        .g_in(g_in), .h_in(h_in), .busy(busy), .done(done),
        .g_table(g_table), .h_table(h_table),
        .mismatch_cnt(mismatch_cnt), .pass(pass)
    );

    always #5 clk = ~clk;

    assign g_in = fu_g[abcd];
    assign h_in = fu_h[abcd];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_sweep(input logic [15:0] eg, input logic [15:0] eh);
        exp_t x;
        int   m = 0;
        for (int i = 0; i < 16; i++)
            if (fu_g[i] !== eg[i] || fu_h[i] !== eh[i]) m++;
        x.g = fu_g;
        x.h = fu_h;
`ifdef SWEEP_COMPARE_EN
        x.mm   = 5'(m);
        x.pass = (m == 0);
`else
        x.mm   = 5'd0;
        x.pass = 1'b0;
`endif
        sb.push_back(x);
        exp_g = eg;
        exp_h = eh;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until done (bounded); optionally pulses start with altered exp at glitch_at,
    // and abort at abort_at (cycle counts after the start-accepting edge).
    task automatic run_to_done(input string tag, input int glitch_at, input int abort_at);
        exp_t x;
        cyc = 0;
        while (cyc < 200 && !done) begin
            if (cyc == glitch_at) begin
                start = 1'b1;
                exp_g = ~exp_g;
                exp_h = ~exp_h;
            end
            abort = (cyc == abort_at);
            if (cyc == 10) chk({tag, "_abcd"}, 32'(abcd), 32'(10 / (S + 1)));
            tick();
            cyc++;
            start = 1'b0;
            abort = 1'b0;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(LAT));
        x = sb.pop_front();
        chk({tag, "_g_table"}, 32'(g_table), 32'(x.g));
        chk({tag, "_h_table"}, 32'(h_table), 32'(x.h));
        chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(x.mm));
        chk({tag, "_pass"}, 32'(pass), 32'(x.pass));
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) dones++;
        end
        chk({tag, "_single_done"}, 32'(dones), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold_g"}, 32'(g_table), 32'(x.g));
        chk({tag, "_hold_pass"}, 32'(pass), 32'(x.pass));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; exp_g = 16'd0; exp_h = 16'd0;
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        chk("rst_abcd", 32'(abcd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tables", 32'({g_table, h_table}), 32'd0);
        chk("rst_mm", 32'(mismatch_cnt), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);

        start_sweep(16'hF37A, 16'h5E0B);
        chk("match_busy", 32'(busy), 32'd1);
        chk("match_abcd0", 32'(abcd), 32'd0);
        run_to_done("match", -1, -1);

        start_sweep(16'hF37B, 16'h5E0A);
        run_to_done("one_off", 10, -1);

        start_sweep(16'h0000, 16'h0000);
        run_to_done("zeros", -1, LAT - 1);

        start_sweep(16'hF37A, 16'h5E0B);
        for (int k = 1; k < 5 * (S + 1) + S; k++) tick();
        chk("abort_abcd", 32'(abcd), 32'd5);
        chk("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e = sb.pop_front();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_g_table", 32'(g_table), 32'h001A);
        chk("abort_h_table", 32'(h_table), 32'h000B);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_mm", 32'(mismatch_cnt), 32'd0);
        chk("abort_abcd_hold", 32'(abcd), 32'd5);
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        start_sweep(16'hF37A, 16'h5E0B);
        for (int k = 1; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = sb.pop_front();
        chk("midrst_abcd", 32'(abcd), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tables", 32'({g_table, h_table}), 32'd0);
        chk("midrst_mm_pass_done", 32'({mismatch_cnt, pass, done}), 32'd0);
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
